// File: rtl/riscv_test_sequencer.sv
`default_nettype none
// riscv_test_sequencer (rev 1.0): loads a program into the core's imem, holds the core in reset,
// runs it for a bounded cycle budget, then checks debug-read registers against an expected table.
module riscv_test_sequencer #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int MAX_CHECKS = 16,
    parameter int RST_CYCLES = 2,
    parameter int CYC_W      = 16,
    localparam int AW        = $clog2(IMEM_DEPTH),
    localparam int CW        = $clog2(MAX_CHECKS)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [AW:0]     prog_len_i,
    input  logic [CYC_W-1:0] run_cycles_i,
    input  logic [CW:0]     num_checks_i,
    output logic [AW-1:0]   prog_raddr_o,
    input  logic [XLEN-1:0] prog_rdata_i,
    output logic            imem_we_o,
    output logic [AW-1:0]   imem_addr_o,
    output logic [XLEN-1:0] imem_wdata_o,
    output logic            core_n_rst_o,
    output logic            core_run_o,
    input  logic            core_halt_i,
    output logic [CW-1:0]   chk_idx_o,
    input  logic [4:0]      chk_reg_i,
    input  logic [XLEN-1:0] chk_val_i,
    output logic [4:0]      dbg_raddr_o,
    input  logic [XLEN-1:0] dbg_rdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [CW:0]     fail_count_o,
    output logic [CW-1:0]   first_fail_o
);
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CRST  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [AW:0]      LEN_MAX  = (AW+1)'(IMEM_DEPTH);
    localparam logic [CW:0]      CHK_MAX  = (CW+1)'(MAX_CHECKS);
    localparam logic [AW:0]      K_ONE    = (AW+1)'(1);
    localparam logic [CW:0]      I_ONE    = (CW+1)'(1);
    localparam logic [RCW-1:0]   RC_ONE   = RCW'(1);
    localparam logic [RCW-1:0]   RC_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CW:0]      FAIL_SAT = {(CW+1){1'b1}};

    logic [2:0]       state_q, state_d;
    logic [AW:0]      len_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CW:0]      nchk_q;
    logic [AW:0]      k_q;
    logic [RCW-1:0]   rc_q;
    logic [CYC_W-1:0] run_q;
    logic [CW:0]      i_q;
    logic             wr_pend_q;
    logic [AW-1:0]    wr_addr_q;
    logic             cmp_q;
    logic [XLEN-1:0]  exp_q;
    logic [CW-1:0]    idx_q;
    logic [CW:0]      fail_q;
    logic [CW-1:0]    first_q;

    logic [AW:0] w_len;
    logic [CW:0] w_nchk;
    logic        w_idle;
    logic        w_issue;
    logic        w_chk;

    assign w_len   = (prog_len_i > LEN_MAX) ? LEN_MAX : prog_len_i;
    assign w_nchk  = (num_checks_i > CHK_MAX) ? CHK_MAX : num_checks_i;
    assign w_idle  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_issue = (state_q == S_LOAD) && (k_q < len_q);
    assign w_chk   = (state_q == S_CHECK) && (i_q < nchk_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_i) state_d = (w_len == '0) ? S_CRST : S_LOAD;
            S_LOAD:         if (k_q == len_q) state_d = S_CRST;
            S_CRST:         if (rc_q == RC_LAST) state_d = (cyc_q == '0) ? S_CHECK : S_RUN;
            S_RUN:          if (core_halt_i || (run_q == cyc_q - CYC_ONE)) state_d = S_CHECK;
            S_CHECK:        if (i_q == nchk_q) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cyc_q     <= '0;
            nchk_q    <= '0;
            k_q       <= '0;
            rc_q      <= '0;
            run_q     <= '0;
            i_q       <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            cmp_q     <= 1'b0;
            exp_q     <= '0;
            idx_q     <= '0;
            fail_q    <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            // Phase counters run only while in their own state and sit at zero otherwise.
            k_q       <= (state_q == S_LOAD)  ? k_q + K_ONE     : '0;
            rc_q      <= (state_q == S_CRST)  ? rc_q + RC_ONE   : '0;
            run_q     <= (state_q == S_RUN)   ? run_q + CYC_ONE : '0;
            i_q       <= (state_q == S_CHECK) ? i_q + I_ONE     : '0;
            wr_pend_q <= w_issue && !abort_i;
            wr_addr_q <= w_issue ? k_q[AW-1:0] : '0;
            cmp_q     <= w_chk && !abort_i;
            exp_q     <= chk_val_i;
            idx_q     <= w_chk ? i_q[CW-1:0] : '0;
            if (w_idle && start_i && !abort_i) begin
                len_q   <= w_len;
                cyc_q   <= run_cycles_i;
                nchk_q  <= w_nchk;
                fail_q  <= '0;
                first_q <= '0;
            end else if (cmp_q && (state_q == S_CHECK) && (dbg_rdata_i != exp_q)) begin
                if (fail_q != FAIL_SAT) fail_q <= fail_q + I_ONE;
                if (fail_q == '0) first_q <= idx_q;
            end
        end
    end

    // The write enable is gated by n_rst so a reset cycle never commits an imem write.
    assign imem_we_o    = wr_pend_q && (state_q == S_LOAD) && n_rst;
    assign imem_addr_o  = imem_we_o ? wr_addr_q : '0;
    assign imem_wdata_o = imem_we_o ? prog_rdata_i : '0;
    assign prog_raddr_o = w_issue ? k_q[AW-1:0] : '0;

    assign core_n_rst_o = (state_q == S_RUN) || (state_q == S_CHECK) || (state_q == S_DONE);
    assign core_run_o   = (state_q == S_RUN);

    assign chk_idx_o    = w_chk ? i_q[CW-1:0] : '0;
    assign dbg_raddr_o  = w_chk ? chk_reg_i : 5'd0;

    assign busy_o       = !w_idle;
    assign done_o       = (state_q == S_DONE);
    assign pass_o       = done_o && (fail_q == '0);
    assign fail_count_o = fail_q;
    assign first_fail_o = first_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// tb_riscv_test_sequencer: randomized bench with ROM, register-file and expected-table models.
module tb_riscv_test_sequencer;
    localparam int XLEN = 32, IMEM_DEPTH = 256, MAX_CHECKS = 16, RST_CYCLES = 2, CYC_W = 16;
    localparam int AW = 8, CW = 4;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            start_i = 1'b0;
    logic            abort_i = 1'b0;
    logic [AW:0]     prog_len_i = '0;
    logic [CYC_W-1:0] run_cycles_i = '0;
    logic [CW:0]     num_checks_i = '0;
    logic [AW-1:0]   prog_raddr_o;
    logic [XLEN-1:0] prog_rdata_i = '0;
    logic            imem_we_o;
    logic [AW-1:0]   imem_addr_o;
    logic [XLEN-1:0] imem_wdata_o;
    logic            core_n_rst_o, core_run_o, core_halt_i;
    logic [CW-1:0]   chk_idx_o;
    logic [4:0]      chk_reg_i;
    logic [XLEN-1:0] chk_val_i;
    logic [4:0]      dbg_raddr_o;
    logic [XLEN-1:0] dbg_rdata_i = '0;
    logic            busy_o, done_o, pass_o;
    logic [CW:0]     fail_count_o;
    logic [CW-1:0]   first_fail_o;

    logic [XLEN-1:0] rom [IMEM_DEPTH];
    logic [XLEN-1:0] rf [32];
    logic [4:0]      tab_reg [MAX_CHECKS];
    logic [XLEN-1:0] tab_val [MAX_CHECKS];
    int unsigned     run_pos = 0;
    int unsigned     halt_tgt = 0;
    logic            halt_en = 1'b0;
    int              n_checks = 0;
    int              n_fail = 0;

    riscv_test_sequencer #(
        .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .MAX_CHECKS(MAX_CHECKS),
        .RST_CYCLES(RST_CYCLES), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start_i(start_i), .abort_i(abort_i),
        .prog_len_i(prog_len_i), .run_cycles_i(run_cycles_i), .num_checks_i(num_checks_i),
        .prog_raddr_o(prog_raddr_o), .prog_rdata_i(prog_rdata_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .core_n_rst_o(core_n_rst_o), .core_run_o(core_run_o), .core_halt_i(core_halt_i),
        .chk_idx_o(chk_idx_o), .chk_reg_i(chk_reg_i), .chk_val_i(chk_val_i),
        .dbg_raddr_o(dbg_raddr_o), .dbg_rdata_i(dbg_rdata_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .fail_count_o(fail_count_o), .first_fail_o(first_fail_o)
    );

    always #5 clk = ~clk;

    // Source ROM and RF debug port both return data one cycle after the address.
    always @(posedge clk) begin
        prog_rdata_i <= rom[prog_raddr_o];
        dbg_rdata_i  <= rf[dbg_raddr_o];
        if (core_run_o) run_pos <= run_pos + 1;
    end

    assign chk_reg_i   = tab_reg[chk_idx_o];
    assign chk_val_i   = tab_val[chk_idx_o];
    assign core_halt_i = halt_en && core_run_o && (run_pos == halt_tgt);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_pack();
        return {24'd0, imem_we_o, core_n_rst_o, core_run_o, busy_o, done_o, pass_o, fail_count_o,
                first_fail_o, prog_raddr_o, imem_addr_o, chk_idx_o, dbg_raddr_o};
    endfunction

    task automatic run_test(input string tag, input int len, input int cyc, input int n,
                            input logic hen, input int halt_at, input logic [15:0] mask,
                            input logic bb);
        int lenc, nc, rexp, efail, efirst, elat, cnt, nwr, bad_wr, nrun, bad_nrst;
        logic seen;
        lenc = (len > IMEM_DEPTH) ? IMEM_DEPTH : len;
        nc   = (n > MAX_CHECKS) ? MAX_CHECKS : n;
        rexp = (hen && (halt_at + 1 < cyc)) ? halt_at + 1 : cyc;
        for (int r = 1; r < 32; r++) rf[r] = $urandom;
        rf[0] = '0;
        efail = 0;
        efirst = 0;
        for (int i = 0; i < MAX_CHECKS; i++) begin
            tab_reg[i] = 5'($urandom_range(0, 31));
            tab_val[i] = rf[tab_reg[i]];
            if (mask[i]) tab_val[i] = tab_val[i] ^ ($urandom | 32'd1);
            if (i < nc && tab_val[i] != rf[tab_reg[i]]) begin
                if (efail == 0) efirst = i;
                efail++;
            end
        end
        elat = ((lenc > 0) ? lenc + 1 : 0) + RST_CYCLES + rexp + nc + 2;
        @(negedge clk);
        prog_len_i   = 9'(len);
        run_cycles_i = 16'(cyc);
        num_checks_i = 5'(n);
        halt_tgt     = run_pos + halt_at;
        halt_en      = hen;
        start_i      = 1'b1;
        cnt = 0; seen = 1'b0; nwr = 0; bad_wr = 0; nrun = 0; bad_nrst = 0;
        while (!seen && cnt < 3000) begin
            @(negedge clk);
            start_i = 1'b0;
            cnt++;
            if (cnt == 1) check_eq({tag, "_started"}, {busy_o, done_o, fail_count_o}, {2'b10, 5'd0});
            if (bb && cnt == 3 && elat > 4) begin
                start_i = 1'b1;
                prog_len_i = 9'd7;
                run_cycles_i = 16'd1;
                num_checks_i = 5'd1;
            end
            if (imem_we_o) begin
                if (imem_addr_o != AW'(nwr) || imem_wdata_o != rom[nwr[AW-1:0]]) bad_wr++;
                if (core_n_rst_o) bad_nrst++;
                nwr++;
            end
            if (core_run_o) begin
                nrun++;
                if (!core_n_rst_o) bad_nrst++;
            end
            if (done_o) seen = 1'b1;
        end
        start_i = 1'b0;
        check_eq({tag, "_done"}, seen, 1);
        check_eq({tag, "_latency"}, cnt, elat);
        check_eq({tag, "_writes"}, nwr, lenc);
        check_eq({tag, "_bad_writes"}, bad_wr, 0);
        check_eq({tag, "_run_cycles"}, nrun, rexp);
        check_eq({tag, "_core_rst"}, bad_nrst, 0);
        check_eq({tag, "_fail_count"}, fail_count_o, efail);
        check_eq({tag, "_first_fail"}, first_fail_o, efirst);
        check_eq({tag, "_pass"}, pass_o, (efail == 0));
        check_eq({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic abort_test();
        int nwr, nbad;
        @(negedge clk);
        prog_len_i = 9'd20; run_cycles_i = 16'd5; num_checks_i = 5'd3; halt_en = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_in_load", {imem_we_o, busy_o}, 2'b11);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        nwr = 0; nbad = 0;
        for (int c = 0; c < 10; c++) begin
            if (imem_we_o) nwr++;
            if (busy_o || core_run_o || done_o) nbad++;
            @(negedge clk);
        end
        check_eq("abort_no_writes", nwr, 0);
        check_eq("abort_idle", nbad, 0);
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        check_eq("abort_over_start", busy_o, 0);
    endtask

    task automatic reset_tests();
        int cnt;
        @(negedge clk);
        prog_len_i = 9'd3; run_cycles_i = 16'd50; num_checks_i = 5'd2; halt_en = 1'b0;
        start_i = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            start_i = 1'b0;
            cnt++;
        end while (!core_run_o && cnt < 100);
        check_eq("rst_run_reached", core_run_o, 1);
        n_rst = 1'b0;
        @(negedge clk);
        check_eq("rst_run_outs", out_pack(), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);
        prog_len_i = 9'd10;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_load_we_pre", imem_we_o, 1);
        n_rst = 1'b0;
        #1;
        check_eq("rst_load_we_gate", {imem_we_o, imem_wdata_o}, 0);
        @(negedge clk);
        check_eq("rst_load_outs", out_pack(), 64'd0);
        n_rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) rom[i] = $urandom;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        for (int i = 0; i < MAX_CHECKS; i++) begin
            tab_reg[i] = '0;
            tab_val[i] = '0;
        end
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", out_pack(), 64'd0);
        n_rst = 1'b1;

        run_test("arith",       4,   7,   4,  1'b0, 0,  16'h0000, 1'b0);
        run_test("mismatch",    4,   7,   4,  1'b0, 0,  16'h000C, 1'b0);
        run_test("halt",        5,   100, 1,  1'b1, 14, 16'h0000, 1'b0);
        run_test("len_clamp",   300, 3,   2,  1'b0, 0,  16'h0000, 1'b0);
        run_test("no_checks",   6,   4,   0,  1'b0, 0,  16'hFFFF, 1'b0);
        run_test("no_run",      4,   0,   3,  1'b1, 0,  16'h0000, 1'b0);
        run_test("chk_clamp",   2,   2,   20, 1'b0, 0,  16'h8000, 1'b0);
        run_test("busy_start",  8,   10,  4,  1'b0, 0,  16'h0001, 1'b1);
        run_test("rerun_clear", 3,   5,   4,  1'b0, 0,  16'h0000, 1'b0);
        abort_test();
        reset_tests();
        for (int t = 0; t < 10; t++) begin
            run_test("rand", $urandom_range(0, 40), $urandom_range(0, 30), $urandom_range(0, 20),
                     1'($urandom_range(0, 1)), $urandom_range(0, 30),
                     ($urandom_range(0, 1) != 0) ? (16'($urandom) & 16'($urandom)) : 16'h0000,
                     1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
